// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sa_pkg
// Description : Shared definitions for the output-stationary systolic array:
//               FSM state encoding, default widths and an index-width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  // Width needed to index n items; never below 1 so a single-row build
  // still has a legal index port.
  function automatic int idx_w(input int n);
    idx_w = (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_pe.sv
`default_nettype none
// ============================================================================
// Module      : sa_pe
// Description : One multiply-accumulate cell of the output-stationary array.
//               Passes a east and b south through one register each and
//               adds a*b into its stationary accumulator every cycle.
// Ports       : clk, rst_n       - clock, synchronous active-low reset
//               a_in, b_in       - operands arriving from west / north
//               clear            - zero the accumulator this edge
//               signed_mode      - 1 = two's complement operands
//               a_out, b_out     - registered pass-through to east / south
//               acc              - accumulator value
// Revision    : 1.0 - initial release
// ============================================================================
module sa_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              clear,
  input  logic              signed_mode,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] w_a_x;
  logic [PROD_W-1:0] w_b_x;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_prod_ext;

  // Operands are widened to the full product width first; the low PROD_W
  // bits of that product are exact for both signed and unsigned operands.
  assign w_a_x  = {{DATA_W{signed_mode & a_in[DATA_W-1]}}, a_in};
  assign w_b_x  = {{DATA_W{signed_mode & b_in[DATA_W-1]}}, b_in};
  assign w_prod = w_a_x * w_b_x;

  if (ACC_W > PROD_W) begin : g_ext_wide
    assign w_prod_ext = {{(ACC_W-PROD_W){signed_mode & w_prod[PROD_W-1]}}, w_prod};
  end else begin : g_ext_exact
    assign w_prod_ext = w_prod;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clear) begin
        acc <= '0;
      end else begin
        acc <= acc + w_prod_ext;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_array_os.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_os
// Description : ROWS x COLS output-stationary systolic MAC array computing
//               C = A(ROWS x K) * B(K x COLS) with runtime K, signed or
//               unsigned operands, optional accumulation across tiles,
//               valid/ready input streaming and row-by-row result drain.
// Ports       : clk, rst_n         - clock, synchronous active-low reset
//               start, k_len,      - tile command, sampled only in IDLE
//               acc_clear, signed_mode
//               busy               - array not idle
//               in_valid/in_ready  - A column / B row beat handshake
//               a_vec, b_vec       - packed A[.][k] and B[k][.] lanes
//               out_valid/out_ready- C row handshake
//               out_row            - packed C[out_row_idx][.]
//               out_row_idx        - row index of out_row
//               done               - pulse after last row accepted
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_os
  import sa_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int KLEN_W = 8,
  localparam int IDX_W = idx_w(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KLEN_W-1:0]      k_len,
  input  logic                   acc_clear,
  input  logic                   signed_mode,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] a_vec,
  input  logic [COLS*DATA_W-1:0] b_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COLS*ACC_W-1:0]  out_row,
  output logic [IDX_W-1:0]       out_row_idx,
  output logic                   done
);

  localparam int               FL_W     = idx_w(ROWS + COLS);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(ROWS + COLS - 2);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);

  logic [1:0]        r_state;
  logic [KLEN_W-1:0] r_k_len;
  logic [KLEN_W-1:0] r_beat_cnt;
  logic [FL_W-1:0]   r_flush_cnt;
  logic              r_signed;
  logic [IDX_W-1:0]  r_row_idx;
  logic              r_done;

  logic w_beat;
  logic w_clear;

  logic [DATA_W-1:0] w_a   [ROWS][COLS+1];
  logic [DATA_W-1:0] w_b   [ROWS+1][COLS];
  logic [ACC_W-1:0]  w_acc [ROWS][COLS];

  // Only an accepted beat carries data; every other cycle feeds zeros so the
  // always-shifting skew chains keep a/b pairs aligned through bubbles.
  assign w_beat  = (r_state == ST_STREAM) && in_valid;
  assign w_clear = (r_state == ST_IDLE) && start && acc_clear;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_signed    <= 1'b0;
      r_row_idx   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_k_len    <= k_len;
            r_signed   <= signed_mode;
            r_beat_cnt <= '0;
            r_row_idx  <= '0;
            r_state    <= (k_len == '0) ? ST_DRAIN : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (in_valid) begin
            r_beat_cnt <= r_beat_cnt + KLEN_W'(1);
            if (r_beat_cnt == r_k_len - KLEN_W'(1)) begin
              r_flush_cnt <= '0;
              r_state     <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // Long enough for the last beat to reach PE(ROWS-1, COLS-1).
          r_flush_cnt <= r_flush_cnt + FL_W'(1);
          if (r_flush_cnt == FL_LAST) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (r_row_idx == ROW_LAST) begin
              r_row_idx <= '0;
              r_done    <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_row_idx <= r_row_idx + IDX_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Input skew: lane n is delayed n cycles before entering the grid edge
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    logic [DATA_W-1:0] w_inj;
    assign w_inj = w_beat ? a_vec[i*DATA_W +: DATA_W] : '0;
    if (i == 0) begin : g_direct
      assign w_a[i][0] = w_inj;
    end else begin : g_delay
      logic [DATA_W-1:0] r_sh [i];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < i; k++) r_sh[k] <= '0;
        end else begin
          r_sh[0] <= w_inj;
          for (int k = 1; k < i; k++) r_sh[k] <= r_sh[k-1];
        end
      end
      assign w_a[i][0] = r_sh[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    logic [DATA_W-1:0] w_inj;
    assign w_inj = w_beat ? b_vec[j*DATA_W +: DATA_W] : '0;
    if (j == 0) begin : g_direct
      assign w_b[0][j] = w_inj;
    end else begin : g_delay
      logic [DATA_W-1:0] r_sh [j];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < j; k++) r_sh[k] <= '0;
        end else begin
          r_sh[0] <= w_inj;
          for (int k = 1; k < j; k++) r_sh[k] <= r_sh[k-1];
        end
      end
      assign w_b[0][j] = r_sh[j-1];
    end
  end

  // --------------------------------------------------------------------------
  // PE grid
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      sa_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_in        (w_a[i][j]),
        .b_in        (w_b[i][j]),
        .clear       (w_clear),
        .signed_mode (r_signed),
        .a_out       (w_a[i][j+1]),
        .b_out       (w_b[i+1][j]),
        .acc         (w_acc[i][j])
      );
    end
  end

  // The east/south pass-throughs of the last column/row leave the grid.
  logic w_unused_edge;
  always_comb begin
    w_unused_edge = 1'b0;
    for (int i = 0; i < ROWS; i++) w_unused_edge = w_unused_edge ^ (^w_a[i][COLS]);
    for (int j = 0; j < COLS; j++) w_unused_edge = w_unused_edge ^ (^w_b[ROWS][j]);
  end

  // --------------------------------------------------------------------------
  // Drain mux and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    out_row = '0;
    if (r_state == ST_DRAIN) begin
      for (int j = 0; j < COLS; j++) out_row[j*ACC_W +: ACC_W] = w_acc[r_row_idx][j];
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign in_ready    = (r_state == ST_STREAM);
  assign out_valid   = (r_state == ST_DRAIN);
  assign out_row_idx = r_row_idx;
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_os.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array_os
// Description : Self-checking bench for systolic_array_os: a 4x4 instance
//               driven from a tile table with a row scoreboard, plus a 2x3
//               instance checked against a signed reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array_os;

  localparam int ROWS = 4, COLS = 4, DW = 8, AW = 32, KW = 8;
  localparam int R2 = 2, C2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 4x4 instance
  logic                 start, acc_clear, signed_mode, in_valid, out_ready;
  logic [KW-1:0]        k_len;
  logic                 busy, in_ready, out_valid, done;
  logic [ROWS*DW-1:0]   a_vec;
  logic [COLS*DW-1:0]   b_vec;
  logic [COLS*AW-1:0]   out_row;
  logic [1:0]           out_row_idx;

  // 2x3 instance
  logic                 d2_start, d2_acc_clear, d2_signed_mode, d2_in_valid, d2_out_ready;
  logic [KW-1:0]        d2_k_len;
  logic                 d2_busy, d2_in_ready, d2_out_valid, d2_done;
  logic [R2*DW-1:0]     d2_a_vec;
  logic [C2*DW-1:0]     d2_b_vec;
  logic [C2*AW-1:0]     d2_out_row;
  logic [0:0]           d2_out_row_idx;

  systolic_array_os #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW), .KLEN_W(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .acc_clear(acc_clear),
    .signed_mode(signed_mode), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_row_idx(out_row_idx), .done(done)
  );

  systolic_array_os #(.ROWS(R2), .COLS(C2), .DATA_W(DW), .ACC_W(AW), .KLEN_W(KW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(d2_start), .k_len(d2_k_len), .acc_clear(d2_acc_clear),
    .signed_mode(d2_signed_mode), .busy(d2_busy), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .a_vec(d2_a_vec), .b_vec(d2_b_vec), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .out_row(d2_out_row), .out_row_idx(d2_out_row_idx), .done(d2_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ext(input logic [7:0] v, input bit s);
    return s ? {{24{v[7]}}, v} : {24'h0, v};
  endfunction

  // --------------------------------------------------------------------------
  // Reference model and scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    int         pat;    // 0: identity A x sequential B, 1: constants, 2: random
    logic [7:0] av;
    logic [7:0] bv;
    int         k;
    bit         sgn;
    bit         clr;
    bit         bub;    // in_valid toggles 1,0,1,0
    bit         stall;  // out_ready low 3 cycles per row
  } tile_t;

  typedef struct {
    int           idx;
    logic [127:0] row;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  ta   [ROWS][16];
  logic [7:0]  tbm  [16][COLS];
  logic [31:0] m_acc[ROWS][COLS];

  task automatic prep(input tile_t t);
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < 16; k++)
        ta[i][k] = (t.pat == 0) ? ((i == k) ? 8'd1 : 8'd0) : (t.pat == 1) ? t.av : 8'($urandom);
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < COLS; j++)
        tbm[k][j] = (t.pat == 0) ? 8'(k*COLS + j + 1) : (t.pat == 1) ? t.bv : 8'($urandom);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        if (t.clr) m_acc[i][j] = 32'h0;
        for (int k = 0; k < t.k; k++)
          m_acc[i][j] = m_acc[i][j] + ext(ta[i][k], t.sgn) * ext(tbm[k][j], t.sgn);
      end
  endtask

  task automatic push_rows();
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      e.idx = r;
      e.row = '0;
      for (int j = 0; j < COLS; j++) e.row[j*AW +: AW] = m_acc[r][j];
      sb_q.push_back(e);
    end
  endtask

  // Output monitor: pops on every accepted row and checks hold-while-stalled.
  bit           stalled = 1'b0;
  logic [127:0] prev_row;
  int           prev_idx;
  exp_t         mon_e;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (stalled) begin
        chk("row_hold", out_row, prev_row);
        chk("idx_hold", out_row_idx, prev_idx);
      end
      if (out_ready) begin
        chk("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          chk("row_idx", out_row_idx, mon_e.idx);
          chk("row_data", out_row, mon_e.row);
        end
        stalled = 1'b0;
      end else begin
        stalled  = 1'b1;
        prev_row = out_row;
        prev_idx = out_row_idx;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // One full tile on the 4x4 instance
  // --------------------------------------------------------------------------
  task automatic run_tile(input tile_t t);
    int  c0, last, exp_first, sent, rows, wait_cnt, guard;
    bit  tog, seen;
    prep(t);
    @(posedge clk); #1;
    start = 1'b1; k_len = KW'(t.k); acc_clear = t.clr; signed_mode = t.sgn;
    c0 = cyc; last = c0;
    push_rows();
    @(posedge clk); #1;
    // Changing command inputs after start must not matter.
    start = 1'b0; k_len = '0; acc_clear = 1'b0; signed_mode = !t.sgn;
    sent = 0; tog = 1'b0; guard = 0;
    while (sent < t.k && guard < 200) begin
      in_valid = !(t.bub && tog);
      for (int i = 0; i < ROWS; i++) a_vec[i*DW +: DW] = in_valid ? ta[i][sent] : 8'hA5;
      for (int j = 0; j < COLS; j++) b_vec[j*DW +: DW] = in_valid ? tbm[sent][j] : 8'h5A;
      @(negedge clk);
      chk("in_ready", in_ready, 1);
      if (in_valid) begin
        last = cyc;
        sent++;
      end
      @(posedge clk); #1;
      tog = !tog;
      guard++;
    end
    // Junk offered outside STREAM must be ignored.
    in_valid = 1'b1; a_vec = '1; b_vec = '1;
    exp_first = (t.k == 0) ? c0 + 1 : last + 8;
    rows = 0; wait_cnt = 0; seen = 1'b0; guard = 0;
    while (rows < ROWS && guard < 300) begin
      out_ready = !t.stall || (wait_cnt >= 3);
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1;
        chk("first_valid_cycle", cyc - c0, exp_first - c0);
      end
      chk("done_early", done, 0);
      if (out_valid) begin
        if (out_ready) begin
          rows++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    if (rows < ROWS) chk("drain_timeout", rows, ROWS);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_single", done, 0);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  tile_t tv[8];
  logic [7:0]   a2[R2][8];
  logic [7:0]   b2[8][C2];
  logic [31:0]  m2[R2][C2];
  logic [127:0] e2;

  initial begin
    rst_n = 1'b0;
    start = 0; acc_clear = 0; signed_mode = 0; in_valid = 0; out_ready = 0; k_len = '0;
    a_vec = '0; b_vec = '0;
    d2_start = 0; d2_acc_clear = 0; d2_signed_mode = 0; d2_in_valid = 0; d2_out_ready = 0;
    d2_k_len = '0; d2_a_vec = '0; d2_b_vec = '0;
    for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) m_acc[i][j] = 32'h0;

    tv[0] = '{0, 8'h00, 8'h00, 4, 1'b0, 1'b1, 1'b0, 1'b0};  // identity -> B rows
    tv[1] = '{1, 8'h80, 8'hFF, 2, 1'b1, 1'b1, 1'b0, 1'b0};  // signed  -> 256
    tv[2] = '{1, 8'h80, 8'hFF, 2, 1'b0, 1'b1, 1'b0, 1'b0};  // unsigned -> 65280
    tv[3] = '{1, 8'h01, 8'h01, 3, 1'b0, 1'b1, 1'b0, 1'b0};  // -> 3
    tv[4] = '{1, 8'h01, 8'h01, 5, 1'b0, 1'b0, 1'b0, 1'b0};  // accumulate -> 8
    tv[5] = '{0, 8'h00, 8'h00, 4, 1'b0, 1'b1, 1'b1, 1'b1};  // bubbles + backpressure
    tv[6] = '{1, 8'h55, 8'h33, 0, 1'b0, 1'b1, 1'b0, 1'b0};  // k_len=0 -> zeros
    tv[7] = '{2, 8'h00, 8'h00, 7, 1'b1, 1'b1, 1'b0, 1'b1};  // random signed

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_row_idx", out_row_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_d2_out", {d2_busy, d2_out_valid, d2_done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) run_tile(tv[t]);

    // Reset during the second STREAM beat, then a fresh tile without
    // acc_clear must see clean accumulators and pipelines.
    @(posedge clk); #1;
    start = 1'b1; k_len = 8'd4; acc_clear = 1'b0; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; a_vec = '1; b_vec = '1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_row", out_row, 0);
    chk("mid_rst_idx", out_row_idx, 0);
    chk("mid_rst_done", done, 0);
    for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) m_acc[i][j] = 32'h0;
    run_tile('{1, 8'h01, 8'h01, 1, 1'b0, 1'b0, 1'b0, 1'b0});  // -> 1

    // 2x3 build, random signed K=7
    for (int i = 0; i < R2; i++) for (int k = 0; k < 8; k++) a2[i][k] = 8'($urandom);
    for (int k = 0; k < 8; k++) for (int j = 0; j < C2; j++) b2[k][j] = 8'($urandom);
    for (int i = 0; i < R2; i++)
      for (int j = 0; j < C2; j++) begin
        m2[i][j] = 32'h0;
        for (int k = 0; k < 7; k++) m2[i][j] = m2[i][j] + ext(a2[i][k], 1'b1) * ext(b2[k][j], 1'b1);
      end
    @(posedge clk); #1;
    d2_start = 1'b1; d2_k_len = 8'd7; d2_acc_clear = 1'b1; d2_signed_mode = 1'b1;
    @(posedge clk); #1;
    d2_start = 1'b0; d2_signed_mode = 1'b0;
    for (int k = 0; k < 7; k++) begin
      d2_in_valid = 1'b1;
      for (int i = 0; i < R2; i++) d2_a_vec[i*DW +: DW] = a2[i][k];
      for (int j = 0; j < C2; j++) d2_b_vec[j*DW +: DW] = b2[k][j];
      @(negedge clk);
      chk("d2_in_ready", d2_in_ready, 1);
      @(posedge clk); #1;
    end
    d2_in_valid = 1'b0; d2_out_ready = 1'b1;
    begin
      int rows2, guard2;
      rows2 = 0; guard2 = 0;
      while (rows2 < R2 && guard2 < 100) begin
        @(negedge clk);
        if (d2_out_valid) begin
          e2 = '0;
          for (int j = 0; j < C2; j++) e2[j*AW +: AW] = m2[rows2][j];
          chk("d2_row_idx", d2_out_row_idx, rows2);
          chk("d2_row_data", d2_out_row, e2);
          rows2++;
        end
        @(posedge clk); #1;
        guard2++;
      end
      if (rows2 < R2) chk("d2_drain_timeout", rows2, R2);
    end
    @(negedge clk);
    chk("d2_done", d2_done, 1);

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
